// File: rtl/dm_pipe.sv
// Pipelined MEM-stage data memory: valid/ready requests, byte/half/word access with
// extension, error detection, fixed-latency in-order responses and an optional post-reset clear.
module dm_pipe #(
    parameter int ADDR_W         = 12,
    parameter int LAT            = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CLR_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} stateT;

    function automatic logic [31:0] laneMerge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00:   r[{off, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   r[{off[1], 4'b0000} +: 16] = wdata[15:0];
            2'b10:   r = wdata;
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] loadExtract(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            2'b10:   r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    stateT             state, stateNext;
    logic [ADDR_W:0]   clrCnt;
    logic              readyR, busyR;
    logic [31:0]       mem [DEPTH];
    logic [LAT-1:0]    pipeValid, pipeErr;
    logic [31:0]       pipeData [LAT];

    logic [ADDR_W-1:0] wordIdx;
    logic [31:0]       curWord, mergedWord, loadData;
    logic              reqErr, accept, storeCommit;
    logic              unusedPc;

    // pc only feeds the external store trace
    assign unusedPc = ^req_pc;

    assign wordIdx = req_addr[ADDR_W+1:2];
    assign curWord = mem[wordIdx];

    // request decode: error, accept, store merge and load extraction
    always_comb begin
        reqErr = (req_size == 2'b11)
               || ((req_size == 2'b01) && req_addr[0])
               || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
               || ((req_addr >> (ADDR_W + 2)) != 32'd0);
        accept      = req_valid && readyR && !reset;
        storeCommit = accept && req_we && !reqErr;
        mergedWord  = laneMerge(curWord, req_wdata, req_size, req_addr[1:0]);
        if (req_we || reqErr) begin
            loadData = 32'd0;
        end else begin
            loadData = loadExtract(curWord, req_size, req_addr[1:0], req_unsigned);
        end
    end

    // next-state: CLEAR runs until the last word is written, READY holds until reset
    always_comb begin
        stateNext = state;
        case (state)
            CLEAR: begin
                if (clrCnt == CLR_LAST) begin
                    stateNext = READY;
                end else begin
                    stateNext = CLEAR;
                end
            end
            READY:   stateNext = READY;
            default: stateNext = READY;
        endcase
    end

    // state, clear counter and registered handshake/busy flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= CLEAR_ON_RESET ? CLEAR : READY;
            clrCnt <= '0;
            readyR <= 1'b0;
            busyR  <= CLEAR_ON_RESET;
        end else begin
            state  <= stateNext;
            if (state == CLEAR) begin
                clrCnt <= clrCnt + CLR_ONE;
            end
            readyR <= (stateNext == READY);
            busyR  <= (stateNext == CLEAR);
        end
    end

    // memory array: not reset, only zeroed by the clear sequence
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clrCnt[ADDR_W-1:0]] <= 32'd0;
            end else if (storeCommit) begin
                mem[wordIdx] <= mergedWord;
            end
        end
    end

    // response pipeline of LAT stages, flushed on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pipeValid <= {LAT{1'b0}};
            pipeErr   <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                pipeData[i] <= 32'd0;
            end
        end else begin
            pipeValid[0] <= accept;
            pipeErr[0]   <= accept && reqErr;
            pipeData[0]  <= accept ? loadData : 32'd0;
            for (int i = 1; i < LAT; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                pipeErr[i]   <= pipeErr[i-1];
                pipeData[i]  <= pipeData[i-1];
            end
        end
    end

    assign req_ready = readyR;
    assign busy      = busyR;
    assign rsp_valid = pipeValid[LAT-1];
    assign rsp_err   = pipeErr[LAT-1];
    assign rsp_rdata = pipeData[LAT-1];
endmodule

// File: tb/tb_dm_pipe.sv
// Directed bench for dm_pipe: three instances (LAT=1/3/2, clear on/off) sharing request fields.
module tb_dm_pipe;
    logic        clk = 1'b0;
    logic        we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata, pc;
    logic [2:0]  vld, rst, rdy, bsy, rv, rerr;
    logic [31:0] rd [3];
    int          tests = 0, fails = 0, traceCnt = 0;

    always #5 clk = ~clk;

    dm_pipe #(.ADDR_W(4), .LAT(1), .CLEAR_ON_RESET(1'b1)) d1 (
        .clk(clk), .reset(rst[0]), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(we),
        .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata), .req_pc(pc),
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(rerr[0]), .busy(bsy[0]));
    dm_pipe #(.ADDR_W(4), .LAT(3), .CLEAR_ON_RESET(1'b0)) d2 (
        .clk(clk), .reset(rst[1]), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(we),
        .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata), .req_pc(pc),
        .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(rerr[1]), .busy(bsy[1]));
    dm_pipe #(.ADDR_W(4), .LAT(2), .CLEAR_ON_RESET(1'b1)) d3 (
        .clk(clk), .reset(rst[2]), .req_valid(vld[2]), .req_ready(rdy[2]), .req_we(we),
        .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata), .req_pc(pc),
        .rsp_valid(rv[2]), .rsp_rdata(rd[2]), .rsp_err(rerr[2]), .busy(bsy[2]));

    // store trace for the LAT=1 instance
    always @(posedge clk) begin
        if (d1.storeCommit) begin
            traceCnt++;
            $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, d1.mergedWord);
        end
    end

    typedef struct {
        logic        w;
        logic [1:0]  s;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] expD;
        logic        expE;
    } vecT;
    vecT tbl [23];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic setReq(input int sel, input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
        vld = 3'b000;
        vld[sel] = 1'b1;
        we = w; size = s; uns = u; addr = a; wdata = d;
        pc = pc + 32'd4;
    endtask

    task automatic idle();
        vld = 3'b000;
    endtask

    task automatic countBusy(input int sel, output int n);
        n = 0;
        while (bsy[sel] && n < 100) begin
            chkb("busy_rsp_quiet", rv[sel], 1'b0);
            chkb("busy_not_ready", rdy[sel], 1'b0);
            n++;
            tick();
        end
    endtask

    initial begin
        int n, expStores;
        logic [31:0] expV [6];
        logic [31:0] expD [6];

        tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, 32'h00000000, 1'b0};
        tbl[2]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h11AA3344, 1'b0};
        tbl[3]  = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'h000011AA, 1'b0};
        tbl[4]  = '{1'b0, 2'b00, 1'b1, 32'h12, 32'h0,        32'h000000AA, 1'b0};
        tbl[5]  = '{1'b0, 2'b00, 1'b0, 32'h12, 32'h0,        32'hFFFFFFAA, 1'b0};
        tbl[6]  = '{1'b0, 2'b10, 1'b0, 32'h02, 32'h0,        32'h00000000, 1'b1};
        tbl[7]  = '{1'b1, 2'b01, 1'b0, 32'h01, 32'h00005555, 32'h00000000, 1'b1};
        tbl[8]  = '{1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'h00000000, 1'b1};
        tbl[9]  = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        32'h00000000, 1'b1};
        tbl[10] = '{1'b1, 2'b10, 1'b0, 32'h40, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        tbl[11] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h11AA3344, 1'b0};
        tbl[12] = '{1'b1, 2'b01, 1'b0, 32'h16, 32'h00008001, 32'h00000000, 1'b0};
        tbl[13] = '{1'b0, 2'b01, 1'b0, 32'h16, 32'h0,        32'hFFFF8001, 1'b0};
        tbl[14] = '{1'b0, 2'b01, 1'b1, 32'h16, 32'h0,        32'h00008001, 1'b0};
        tbl[15] = '{1'b0, 2'b00, 1'b0, 32'h17, 32'h0,        32'hFFFFFF80, 1'b0};
        tbl[16] = '{1'b0, 2'b00, 1'b1, 32'h14, 32'h0,        32'h00000000, 1'b0};
        tbl[17] = '{1'b1, 2'b00, 1'b0, 32'h13, 32'h0000007F, 32'h00000000, 1'b0};
        tbl[18] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h7FAA3344, 1'b0};
        tbl[19] = '{1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        32'h00003344, 1'b0};
        tbl[20] = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'h00000000, 1'b0};
        tbl[21] = '{1'b0, 2'b10, 1'b1, 32'h14, 32'h0,        32'h80010000, 1'b0};
        tbl[22] = '{1'b0, 2'b10, 1'b0, 32'h00, 32'h0,        32'h00000000, 1'b0};

        vld = 3'b000; rst = 3'b111; we = 1'b0; size = 2'b10; uns = 1'b0;
        addr = 32'd0; wdata = 32'd0; pc = 32'h00001000;
        tick();
        tick();
        chkb("rst_ready_d1", rdy[0], 1'b0);
        chkb("rst_busy_d1", bsy[0], 1'b1);
        chkb("rst_busy_d2", bsy[1], 1'b0);
        chkb("rst_ready_d2", rdy[1], 1'b0);
        chk("rst_rsp_valid", {29'd0, rv}, 32'd0);
        chk("rst_rsp_err", {29'd0, rerr}, 32'd0);
        chk("rst_rdata_d1", rd[0], 32'd0);

        // clear phase of d1/d3 with a store to word 2 presented while not ready
        rst = 3'b010;
        setReq(0, 1'b1, 2'b10, 1'b0, 32'h08, 32'h0000FFFF);
        countBusy(0, n);
        idle();
        chk("clear_len_d1", 32'(n), 32'd16);

        // d2 skips the clear: ready one cycle after reset release
        rst[1] = 1'b0;
        chkb("d2_ready_0", rdy[1], 1'b0);
        tick();
        chkb("d2_ready_1", rdy[1], 1'b1);

        expStores = 0;
        for (int i = 0; i < 23; i++) begin
            if (tbl[i].w && !tbl[i].expE) expStores++;
            setReq(0, tbl[i].w, tbl[i].s, tbl[i].u, tbl[i].a, tbl[i].d);
            tick();
            chkb($sformatf("vec%0d_valid", i), rv[0], 1'b1);
            chk($sformatf("vec%0d_rdata", i), rd[0], tbl[i].expD);
            chkb($sformatf("vec%0d_err", i), rerr[0], tbl[i].expE);
        end
        idle();
        tick();
        chkb("after_vec_valid", rv[0], 1'b0);
        chk("trace_count", 32'(traceCnt), 32'(expStores));

        // clear on reset wipes a pre-loaded word
        setReq(0, 1'b1, 2'b10, 1'b0, 32'h0C, 32'hDEADBEEF);
        tick();
        setReq(0, 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
        tick();
        chk("preload", rd[0], 32'hDEADBEEF);
        idle();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chkb("reclear_busy", bsy[0], 1'b1);
        countBusy(0, n);
        chk("reclear_len", 32'(n), 32'd16);
        setReq(0, 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
        tick();
        idle();
        chk("cleared_word3", rd[0], 32'h00000000);
        chkb("cleared_word3_valid", rv[0], 1'b1);

        // LAT=3 back-to-back loads
        for (int i = 0; i < 3; i++) begin
            setReq(1, 1'b1, 2'b10, 1'b0, 32'(4 * i), 32'h000000A0 + 32'(i));
            tick();
        end
        idle();
        repeat (5) tick();
        expV = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd0};
        expD = '{32'd0, 32'd0, 32'hA0, 32'hA1, 32'hA2, 32'd0};
        for (int k = 0; k < 6; k++) begin
            if (k < 3) setReq(1, 1'b0, 2'b10, 1'b0, 32'(4 * k), 32'h0);
            else idle();
            tick();
            chk($sformatf("lat3_valid%0d", k), {31'd0, rv[1]}, expV[k]);
            chk($sformatf("lat3_rdata%0d", k), rd[1], expD[k]);
        end

        // d2: store on the reset edge is dropped, earlier contents survive reset
        setReq(1, 1'b1, 2'b10, 1'b0, 32'h04, 32'hBAD00BAD);
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        idle();
        chkb("d2_rst_ready", rdy[1], 1'b0);
        chkb("d2_rst_valid", rv[1], 1'b0);
        tick();
        chkb("d2_ready_again", rdy[1], 1'b1);
        setReq(1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
        tick();
        idle();
        tick();
        tick();
        chkb("survive_valid", rv[1], 1'b1);
        chk("survive_rdata", rd[1], 32'h000000A1);

        // d3 (LAT=2): reset with loads in flight, then a reset in the middle of the clear
        setReq(2, 1'b1, 2'b10, 1'b0, 32'h00, 32'h00000055);
        tick();
        setReq(2, 1'b1, 2'b10, 1'b0, 32'h3C, 32'h00000066);
        tick();
        setReq(2, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
        tick();
        setReq(2, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
        tick();
        chkb("d3_load_valid", rv[2], 1'b1);
        chk("d3_load_rdata", rd[2], 32'h00000066);
        rst[2] = 1'b1;
        tick();
        chkb("d3_flush_valid", rv[2], 1'b0);
        rst[2] = 1'b0;
        idle();
        for (int k = 0; k < 5; k++) begin
            chkb("d3_partial_busy", bsy[2], 1'b1);
            chkb("d3_partial_valid", rv[2], 1'b0);
            tick();
        end
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        countBusy(2, n);
        chk("d3_restart_len", 32'(n), 32'd16);
        setReq(2, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
        tick();
        setReq(2, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
        tick();
        idle();
        chkb("d3_w15_valid", rv[2], 1'b1);
        chk("d3_w15_cleared", rd[2], 32'h00000000);
        tick();
        chkb("d3_w0_valid", rv[2], 1'b1);
        chk("d3_w0_cleared", rd[2], 32'h00000000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dm_pipe.md
# dm_pipe

Parametrised pipelined data memory for the MEM stage. It adds four things to a single-cycle word array:
- a valid/ready request handshake;
- configurable read latency;
- byte, halfword and word loads and stores, with sign or zero extension on loads;
- misalignment and out-of-range detection, plus an optional hardware clear sequence after reset.

Every accepted request returns exactly one response, in order, a fixed number of cycles later.

## Interface
- ADDR_W, 12, word-address bits; depth DEPTH = 2^ADDR_W 32-bit words
- LAT, 1, read/response latency in cycles, legal 1..4
- CLEAR_ON_RESET, 1, 1: zero every word after reset via the CLEAR state; 0: skip the clear
- Clock is `clk`. Reset is `reset`, synchronous and active-high.
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept this cycle
- req_we  in  1  1 store, 0 load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low-order bits used for byte/half
- req_pc  in  32  PC of the instruction, trace only
- rsp_valid  out  1  response present
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request was misaligned, out of range, or reserved size
- busy  out  1  clear sequence in progress

## Operation
- States: CLEAR and READY.
- Reset asserted: next state is CLEAR if CLEAR_ON_RESET=1, otherwise READY. Clear counter resets to 0 and the response pipeline is flushed.
- CLEAR:
  - Writes 0 to word[cnt] each cycle, cnt += 1.
  - After word DEPTH-1 is written, moves to READY, so CLEAR lasts exactly DEPTH cycles.
  - req_ready=0 and busy=1 throughout.
- READY: req_ready=1 and busy=0; never leaves except on reset.
- Accept: req_valid && req_ready at a rising edge. One request per cycle, no bubbles required.
- Error: any one of the following sets err and suppresses the request.
  - req_size=11.
  - req_size=01 with addr[0]=1.
  - req_size=10 with addr[1:0]≠0.
  - addr[31:ADDR_W+2]≠0.
- Store, no error:
  - Commits at the accept edge to word addr[ADDR_W+1:2].
  - Byte store writes lane addr[1:0] (byte k at bits 8k+7:8k). Half store writes lane addr[1]. Other lanes are preserved.
- Trace: each committed store prints `"%d@%h: *%h <= %h"` with $time, req_pc, {addr[31:2],2'b00}, and the full merged word. No trace is printed for errored stores or for CLEAR.
- Load, no error:
  - Word is sampled at the accept edge; stores committed on earlier edges are visible.
  - Lane is selected by addr[1:0] or addr[1], then extended per req_unsigned. Word loads ignore req_unsigned.
- Response: rsp_valid, rsp_rdata and rsp_err are carried LAT stages after accept. Stores give rdata=0, err as computed. Errored loads give rdata=0, err=1.
- The memory array is not reset except via CLEAR. With CLEAR_ON_RESET=0, contents survive reset. Simulation initialises every word to 0.

## Timing
- Reset values: req_ready=0, busy=CLEAR_ON_RESET, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- First accept is possible DEPTH cycles after reset deasserts if CLEAR_ON_RESET=1, otherwise 1 cycle after.
- Request accepted at edge n gives rsp_valid=1 during the cycle after edge n+LAT-1. With LAT=1 it is valid in the cycle immediately following acceptance.
- Throughput is 1 request per cycle. Responses keep request order, with no backpressure on rsp.
- Store at edge n followed by load of the same word at edge n+1: the load returns the merged data.
- req_valid while req_ready=0: ignored, no response, no side effect.
- Reset in the middle of a burst:
  - In-flight responses are dropped; rsp_valid=0 in the cycle after the reset edge.
  - Partially cleared memory restarts the clear from cnt=0.
  - A store accepted on the reset edge is not committed.
- The clear counter is ADDR_W+1 bits wide and terminates exactly at DEPTH-1 with no wrap.

## Test plan
- ADDR_W=4, CLEAR_ON_RESET=1: pre-load word 3 with 0xDEADBEEF, pulse reset for one cycle -> busy=1 and req_ready=0 for 16 cycles, then a load of word 3 returns 0x00000000.
- LAT=1: sw 0x11223344 @0x10, then sb 0xAA @0x12 -> trace shows `*00000010 <= 11aa3344`. Then lh @0x12 signed -> 0x000011AA; lbu @0x12 -> 0x000000AA; lb @0x12 -> 0xFFFFFFAA.
- LAT=3: back-to-back loads of @0x0, @0x4, @0x8 on consecutive edges -> three consecutive rsp_valid cycles starting 3 cycles after the first accept, with data in order.
- Errors: lw @0x2, sh @0x1, size=11, and lw @(DEPTH*4) -> each gives rsp_err=1, rdata=0. Memory is unchanged and no trace line is printed.
- Reset at LAT=2 with two loads in flight -> no rsp_valid after the reset edge; the CLEAR sequence restarts from word 0.
- CLEAR_ON_RESET=0: store, reset, load same word -> original data returned; req_ready=1 one cycle after reset deasserts.
